// File: rtl/ahb_apb_pkg.sv
// Shared types and AHB encodings for the AHB-to-APB bridge controller.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ENABLE,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Combinational APB address map decode: range hit and slave index.
module ahb_apb_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NSLV      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000,
  parameter int unsigned IW        = idx_width(NSLV)
) (
  input  logic [31:0]   haddr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  localparam int unsigned SHIFT = $clog2(SLV_SIZE);
  // 33-bit limit so a map ending exactly at 4 GiB does not wrap
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(NSLV) * {1'b0, SLV_SIZE};

  logic [31:0] offset;

  always_comb begin
    offset = haddr - BASE_ADDR;
    hit    = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr} < LIMIT);
    idx    = IW'(offset >> SHIFT);
  end

endmodule

// File: rtl/ahb_apb_ctrl.sv
// AHB slave sequencer: turns single AHB transfers into APB SETUP/ENABLE accesses.
module ahb_apb_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NSLV      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic            clock,
  input  logic            Hresetn,
  input  logic [1:0]      Htrans,
  input  logic            Hwrite,
  input  logic            Hreadyin,
  input  logic [31:0]     Haddr,
  input  logic [31:0]     Hwdata,
  output logic            Hreadyout,
  output logic [1:0]      Hresp,
  output logic [31:0]     Hrdata,
  output logic [NSLV-1:0] Pselx,
  output logic            Penable,
  output logic            Pwrite,
  output logic [31:0]     Paddr,
  output logic [31:0]     Pwdata,
  input  logic [31:0]     Prdata
);

  localparam int unsigned IW = idx_width(NSLV);

  state_t          state, state_n;
  logic            hit;
  logic [IW-1:0]   idx, idx_q;
  logic [31:0]     addr_q, wdata_q;
  logic            write_q;
  logic            valid, accepting, take;
  logic [NSLV-1:0] sel_onehot;

  ahb_apb_decoder #(
    .NSLV      (NSLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SIZE  (SLV_SIZE),
    .IW        (IW)
  ) u_decoder (
    .haddr (Haddr),
    .hit   (hit),
    .idx   (idx)
  );

  always_comb begin
    valid     = Hreadyin && (Htrans inside {HTRANS_NONSEQ, HTRANS_SEQ});
    accepting = state inside {IDLE, ENABLE, ERR2};
    take      = accepting && valid && hit;
    state_n   = state;
    case (state)
      IDLE, ENABLE, ERR2: begin
        if (valid && hit)  state_n = Hwrite ? WWAIT : SETUP;
        else if (valid)    state_n = ERR1;
        else               state_n = IDLE;
      end
      WWAIT:   state_n = SETUP;
      SETUP:   state_n = ENABLE;
      ERR1:    state_n = ERR2;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) state <= IDLE;
    else          state <= state_n;
  end

  // address/direction only move on a decoded hit, so Paddr is untouched by error responses
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (take) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
        idx_q   <= idx;
      end
      if (state == WWAIT) wdata_q <= Hwdata;
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < NSLV; i++)
      sel_onehot[i] = (idx_q == IW'(i));
  end

  // strobes decode from the async-reset state register, so reset drops them at once
  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = HRESP_OKAY;
    Hrdata    = '0;
    Pselx     = '0;
    Penable   = 1'b0;
    case (state)
      WWAIT: Hreadyout = 1'b0;
      SETUP: begin
        Pselx     = sel_onehot;
        Hreadyout = 1'b0;
      end
      ENABLE: begin
        Pselx   = sel_onehot;
        Penable = 1'b1;
        if (!write_q) Hrdata = Prdata;
      end
      ERR1: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b0;
      end
      ERR2: Hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign Paddr  = addr_q;
  assign Pwrite = write_q;
  assign Pwdata = wdata_q;

endmodule
